// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-master / one-slave memory-bus arbiter and ready generator.
//   Master 0 is the debug unit, master 1 the CPU core. One request is granted
//   in IDLE, its address/data/strobes are latched, the slave cycle runs for
//   WAIT_STATES+1 cycles (ACCESS), and the granted master gets a one-cycle
//   ready pulse (RESP) with the captured read data.
//
// Handshake: a master raises mN_valid with adr/wdata/wstrb and holds it until
//   it sees mN_ready high for one cycle. Inputs are sampled only in IDLE, so a
//   master may drop or change them after the grant without effect; the access
//   still completes and still pulses ready. mN_rdata is valid in the ready
//   cycle and holds until that master's next completed access.
//
// Ports:
//   clk, n_reset              clock, asynchronous active-low reset
//   mN_valid/adr/wdata/wstrb  master N request (wstrb == 0 means read)
//   mN_rdata/mN_ready         master N read data and completion pulse
//   s_op/s_adr/s_di/s_wren    slave bus cycle, address, write data, byte enables
//   s_rdata                   OR-combined slave read data
//   busy                      high whenever the engine is not IDLE
//   dbg_state                 current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          ROUND_ROBIN = 1'b0
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_op,
  output logic [31:0] s_adr,
  output logic [31:0] s_di,
  output logic [3:0]  s_wren,
  input  logic [31:0] s_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        grant_q, grant_d;           // index of the master being served
  logic        last_grant_q, last_grant_d; // reset to 1 so m0 wins the first tie
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        pick;

  // Grant choice for this IDLE cycle; only meaningful when some valid is high.
  always_comb begin
    if (m0_valid && m1_valid) begin
      pick = ROUND_ROBIN ? ~last_grant_q : 1'b0;
    end else begin
      pick = m1_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    adr_d        = adr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          grant_d      = pick;
          last_grant_d = pick;
          adr_d        = pick ? m1_adr   : m0_adr;
          wdata_d      = pick ? m1_wdata : m0_wdata;
          wstrb_d      = pick ? m1_wstrb : m0_wstrb;
          wait_d       = 4'(WAIT_STATES);
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_q == 4'd0) begin
          // Final slave cycle: writes capture too, masters ignore that value.
          if (grant_q) begin
            m1_rdata_d = s_rdata;
          end else begin
            m0_rdata_d = s_rdata;
          end
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      wait_q       <= 4'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      adr_q        <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      m0_rdata_q   <= 32'd0;
      m1_rdata_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      adr_q        <= adr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // All slave-side outputs come straight from registers, so they are stable
  // for the whole access; s_adr keeps its last value outside ACCESS.
  assign s_op      = (state_q == ST_ACCESS);
  assign s_adr     = adr_q;
  assign s_di      = wdata_q;
  assign s_wren    = s_op ? wstrb_q : 4'd0;
  assign m0_ready  = (state_q == ST_RESP) && !grant_q;
  assign m1_ready  = (state_q == ST_RESP) && grant_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
